// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step controller: divides clk by a programmable period and issues
// one-cycle CPU clock-enable pulses, counting them and halting on breakpoint hits.
module cpu_clock_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 50,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_hit,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             cpu_clk_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             en_q, en_d;
  logic             tick;

  // A divider reload restarts the period, so the terminal count of the old period is dropped.
  always_comb begin
    tick  = (cnt_q == div_q) && !div_load;
    div_d = div_q;
    cnt_d = cnt_q + 1'b1;
    if (div_load) begin
      div_d = div_value;
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d = '0;
    end
    en_d     = tick && (state_q != ST_HALT) && !halt_req;
    cycles_d = cycles_q + {{(CNT_W-1){1'b0}}, en_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HALT;
      div_q    <= DIV_W'(DEFAULT_DIV);
      cnt_q    <= '0;
      en_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      cycles_q <= cycles_d;
      // halt_req outranks every other request in every state.
      if (halt_req) begin
        state_q <= ST_HALT;
      end else begin
        case (state_q)
          ST_HALT: begin
            if (step_req)     state_q <= ST_STEP;
            else if (run_req) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (step_req)             state_q <= ST_STEP;
            else if (tick && bp_hit)  state_q <= ST_HALT;
          end
          ST_STEP: begin
            if (tick) state_q <= ST_HALT;
          end
          default: state_q <= ST_HALT;
        endcase
      end
    end
  end

  assign cpu_clk_en  = en_q;
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign cycle_count = cycles_q;

endmodule
